alu32_arbiter: RTL and testbench

- Time-shares the single combinational 32-bit ALU datapath between two independent requesters.
- Each requester has a valid/ready command channel and a valid/ready response channel.
- Operands are registered before they drive the ALU, and the ALU result is registered on the way back, so the ALU input-to-output path never chains through requester logic.
- One operation is in flight at a time; requesters are granted round-robin.

---
 rtl/alu32_arb_pkg.sv | 23 ++
 rtl/alu32_arb_rr2.sv | 23 ++
 rtl/alu32_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_alu32_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu32_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Contents: default widths, ALU opcode encodings and the arbiter FSM state type.
package alu32_arb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned OP_W_DEF   = 3;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NOT   = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_TRUNC = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu32_arb_rr2.sv
// Two-way round-robin picker (combinational).
// Ports:
//   req        in  2  request vector, bit i = requester i valid
//   last_grant in  1  index of the requester granted most recently
//   gnt        out 2  one-hot grant, or zero when nothing is requested
module alu32_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contention: favour whoever did not win last time.
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu32_arbiter.sv
// Time-shares one external combinational ALU between two requesters.
// Operands are registered into alu_* on accept, the ALU result is registered into the
// owner's response register one cycle later, and the response is held until consumed.
// One operation is in flight at a time; contention is resolved round-robin.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready/in1/in2/ci/op   command channel of requester N (N = 0, 1)
//   rspN_valid/ready/data/co         response channel of requester N
//   alu_in1/in2/ci/op                registered operands driving the ALU
//   alu_out/alu_co                   ALU result and carry-out
//   stat0_cnt/stat1_cnt              completed-op counters
// Build option: define ALU_ARB_STATS_EN to enable the saturating completed-op counters;
// otherwise stat*_cnt are tied to zero and no counter flops exist.
module alu32_arbiter
    import alu32_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,
    input  logic              req0_ci,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,
    input  logic              req1_ci,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_co,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_co,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic              alu_ci,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_co,
    output logic [15:0]       stat0_cnt,
    output logic [15:0]       stat1_cnt
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
    logic              alu_ci_q, alu_ci_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic              rsp0_co_q, rsp0_co_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
    logic              rsp1_co_q, rsp1_co_d;
    logic [1:0]        gnt;

    alu32_arb_rr2 u_rr2 (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_ci_d     = alu_ci_q;
        alu_op_d     = alu_op_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp0_co_d    = rsp0_co_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;
        rsp1_co_d    = rsp1_co_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = gnt[0];
                req1_ready = gnt[1];
                if (gnt[0]) begin
                    alu_in1_d    = req0_in1;
                    alu_in2_d    = req0_in2;
                    alu_ci_d     = req0_ci;
                    alu_op_d     = req0_op;
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (gnt[1]) begin
                    alu_in1_d    = req1_in1;
                    alu_in2_d    = req1_in2;
                    alu_ci_d     = req1_ci;
                    alu_op_d     = req1_op;
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // ALU has had a full cycle to settle from the registered operands.
                if (!owner_q) begin
                    rsp0_data_d  = alu_out;
                    rsp0_co_d    = alu_co;
                    rsp0_valid_d = 1'b1;
                end else begin
                    rsp1_data_d  = alu_out;
                    rsp1_co_d    = alu_co;
                    rsp1_valid_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (!owner_q && rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (owner_q && rsp1_ready) begin
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;  // requester 0 wins the first contention
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_ci_q     <= 1'b0;
            alu_op_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_co_q    <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_co_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_ci_q     <= alu_ci_d;
            alu_op_q     <= alu_op_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_co_q    <= rsp0_co_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_co_q    <= rsp1_co_d;
        end
    end

    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_ci     = alu_ci_q;
    assign alu_op     = alu_op_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp0_co    = rsp0_co_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp1_co    = rsp1_co_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat0_q, stat0_d;
    logic [15:0] stat1_q, stat1_d;

    // Count response handshakes, saturating at all-ones.
    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (rsp0_valid_q && rsp0_ready && (stat0_q != 16'hFFFF)) begin
            stat0_d = stat0_q + 16'd1;
        end
        if (rsp1_valid_q && rsp1_ready && (stat1_q != 16'hFFFF)) begin
            stat1_d = stat1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0_q <= 16'h0000;
            stat1_q <= 16'h0000;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat0_cnt = stat0_q;
    assign stat1_cnt = stat1_q;
`else
    assign stat0_cnt = 16'h0000;
    assign stat1_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed testbench for alu32_arbiter with a behavioural ALU attached.
module tb_alu32_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_ci;
    logic [31:0] req0_in1, req0_in2;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready, req1_ci;
    logic [31:0] req1_in1, req1_in2;
    logic [2:0]  req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_co;
    logic [31:0] rsp0_data;
    logic        rsp1_valid, rsp1_ready, rsp1_co;
    logic [31:0] rsp1_data;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_ci, alu_co;
    logic [2:0]  alu_op;
    logic [15:0] stat0_cnt, stat1_cnt;

    int checks;
    int errors;

    alu32_arbiter #(
        .DATA_W (32),
        .OP_W   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_in1   (req0_in1),
        .req0_in2   (req0_in2),
        .req0_ci    (req0_ci),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_in1   (req1_in1),
        .req1_in2   (req1_in2),
        .req1_ci    (req1_ci),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_co    (rsp0_co),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_co    (rsp1_co),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_ci     (alu_ci),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_co     (alu_co),
        .stat0_cnt  (stat0_cnt),
        .stat1_cnt  (stat1_cnt)
    );

    // Behavioural ALU: carry-out only meaningful for ADD.
    always_comb begin
        alu_out = 32'h0;
        alu_co  = 1'b0;
        case (alu_op)
            3'd0: alu_out = alu_in1 & alu_in2;
            3'd1: alu_out = alu_in1 | alu_in2;
            3'd2: alu_out = alu_in1 ^ alu_in2;
            3'd3: alu_out = ~alu_in1;
            3'd4: {alu_co, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'h0, alu_ci};
            3'd5: alu_out = alu_in1 << alu_in2[4:0];
            3'd6: alu_out = alu_in1 >> alu_in2[4:0];
            default: alu_out = {16'h0, alu_in1[15:0]};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [2:0] op);
        req0_in1 = a; req0_in2 = b; req0_ci = c; req0_op = op; req0_valid = 1'b1;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [2:0] op);
        req1_in1 = a; req1_in2 = b; req1_ci = c; req1_op = op; req1_valid = 1'b1;
    endtask

    // Issue one command on requester `who` and collect its response (rsp_ready assumed 1).
    task automatic do_op(input int who, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [2:0] op,
                         output logic [31:0] data, output logic co);
        int n;
        if (who == 0) drive0(a, b, c, op);
        else          drive1(a, b, c, op);
        #1;
        n = 0;
        while (!((who == 0) ? req0_ready : req1_ready) && n < 20) begin
            tick(); n++;
        end
        checks++;
        if (n >= 20) begin
            $display("FAIL do_op_accept who=%0d: ready=0 after %0d cycles, required 1", who, n);
            errors++;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!((who == 0) ? rsp0_valid : rsp1_valid) && n < 10) begin
            tick(); n++;
        end
        checks++;
        if (n >= 10) begin
            $display("FAIL do_op_rsp who=%0d: rsp_valid=0 after %0d cycles, required 1", who, n);
            errors++;
        end
        data = (who == 0) ? rsp0_data : rsp1_data;
        co   = (who == 0) ? rsp0_co : rsp1_co;
        tick();
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_co, rsp1_co} !== 4'b0) begin
            $display("FAIL reset_valid_co: got %b, required 0000",
                     {rsp0_valid, rsp1_valid, rsp0_co, rsp1_co});
            errors++;
        end
        checks++;
        if ({rsp0_data, rsp1_data} !== 64'h0) begin
            $display("FAIL reset_rsp_data: got %h/%h, required 0/0", rsp0_data, rsp1_data);
            errors++;
        end
        checks++;
        if ({alu_in1, alu_in2, alu_ci, alu_op} !== 68'h0) begin
            $display("FAIL reset_alu_regs: got %h %h %b %h, required all 0",
                     alu_in1, alu_in2, alu_ci, alu_op);
            errors++;
        end
        checks++;
        if ({stat0_cnt, stat1_cnt} !== 32'h0) begin
            $display("FAIL reset_stats: got %h/%h, required 0/0", stat0_cnt, stat1_cnt);
            errors++;
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_op;
        drive0(32'hFFFF_FFFF, 32'h1, 1'b0, 3'd4);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL single_ready: got r0=%b r1=%b, required r0=1 r1=0",
                     req0_ready, req1_ready);
            errors++;
        end
        tick();  // accept edge N
        req0_valid = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b0 || alu_in1 !== 32'hFFFF_FFFF || alu_op !== 3'd4) begin
            $display("FAIL single_exec: got rsp0_valid=%b alu_in1=%h op=%0d, required 0 ffffffff 4",
                     rsp0_valid, alu_in1, alu_op);
            errors++;
        end
        tick();  // edge N+1
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0 || rsp0_co !== 1'b1) begin
            $display("FAIL single_rsp: got v=%b d=%h co=%b, required v=1 d=00000000 co=1",
                     rsp0_valid, rsp0_data, rsp0_co);
            errors++;
        end
        checks++;
        if (rsp1_valid !== 1'b0 || rsp1_data !== 32'h0) begin
            $display("FAIL single_rsp1_untouched: got v=%b d=%h, required 0/0",
                     rsp1_valid, rsp1_data);
            errors++;
        end
        tick();  // handshake
        checks++;
        if (rsp0_valid !== 1'b0) begin
            $display("FAIL single_rsp_clear: got %b, required 0", rsp0_valid);
            errors++;
        end
    endtask

    task automatic test_contention;
        int g;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            drive0(32'h0000_F0F0, 32'h0000_FF00, 1'b0, 3'd0);
            drive1(32'h0000_000F, 32'h0000_00F0, 1'b0, 3'd1);
            #1;
            g = k % 2;
            checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                $display("FAIL contention_grant k=%0d: got r0=%b r1=%b, required winner %0d",
                         k, req0_ready, req1_ready, g);
                errors++;
            end
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            tick();
            checks++;
            if (g == 0) begin
                if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0000_F000 || rsp1_valid !== 1'b0) begin
                    $display("FAIL contention_rsp0 k=%0d: got v0=%b d=%h v1=%b, required 1 0000f000 0",
                             k, rsp0_valid, rsp0_data, rsp1_valid);
                    errors++;
                end
            end else begin
                if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h0000_00FF || rsp0_valid !== 1'b0) begin
                    $display("FAIL contention_rsp1 k=%0d: got v1=%b d=%h v0=%b, required 1 000000ff 0",
                             k, rsp1_valid, rsp1_data, rsp0_valid);
                    errors++;
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        rsp1_ready = 1'b0;
        drive1(32'h0000_1234, 32'h0000_FFFF, 1'b0, 3'd2);
        #1;
        tick();
        req1_valid = 1'b0;
        tick();
        drive0(32'h0F0F_0F0F, 32'h0, 1'b0, 3'd3);  // pending while rsp1 is stalled
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h0000_EDCB ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                $display("FAIL backpressure_hold i=%0d: got v=%b d=%h r0=%b r1=%b, required 1 0000edcb 0 0",
                         i, rsp1_valid, rsp1_data, req0_ready, req1_ready);
                errors++;
            end
            tick();
        end
        rsp1_ready = 1'b1;
        tick();
        checks++;
        if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
            $display("FAIL backpressure_release: got v1=%b r0=%b, required 0 1",
                     rsp1_valid, req0_ready);
            errors++;
        end
        tick();
        req0_valid = 1'b0;
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'hF0F0_F0F0) begin
            $display("FAIL backpressure_next: got v=%b d=%h, required 1 f0f0f0f0",
                     rsp0_valid, rsp0_data);
            errors++;
        end
        tick();
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic        c;
        drive0(32'd5, 32'd6, 1'b0, 3'd4);
        #1;
        tick();  // accepted, now in EXEC
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || alu_in1 !== 32'h0 || alu_in2 !== 32'h0 ||
            alu_op !== 3'd0 || rsp0_data !== 32'h0) begin
            $display("FAIL reset_mid_values: got v=%b in1=%h in2=%h op=%0d d=%h, required all 0",
                     rsp0_valid, alu_in1, alu_in2, alu_op, rsp0_data);
            errors++;
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                $display("FAIL reset_mid_no_rsp i=%0d: got v0=%b v1=%b, required 0 0",
                         i, rsp0_valid, rsp1_valid);
                errors++;
            end
        end
        do_op(0, 32'd5, 32'd6, 1'b1, 3'd4, d, c);
        checks++;
        if (d !== 32'd12 || c !== 1'b0) begin
            $display("FAIL reset_mid_next: got d=%h co=%b, required 0000000c 0", d, c);
            errors++;
        end
    endtask

    task automatic test_shift;
        logic [31:0] d;
        logic        c;
        do_op(1, 32'h1, 32'd31, 1'b0, 3'd5, d, c);
        checks++;
        if (d !== 32'h8000_0000) begin
            $display("FAIL shift_shl: got %h, required 80000000", d);
            errors++;
        end
        do_op(0, 32'h8000_0000, 32'd4, 1'b0, 3'd6, d, c);
        checks++;
        if (d !== 32'h0800_0000) begin
            $display("FAIL shift_shr: got %h, required 08000000", d);
            errors++;
        end
    endtask

    task automatic test_stats;
        logic [31:0] d;
        logic        c;
        apply_reset();
        for (int i = 0; i < 3; i++) do_op(0, i, 32'd1, 1'b0, 3'd4, d, c);
        for (int i = 0; i < 2; i++) do_op(1, i, 32'd2, 1'b0, 3'd1, d, c);
`ifdef ALU_ARB_STATS_EN
        checks++;
        if (stat0_cnt !== 16'd3 || stat1_cnt !== 16'd2) begin
            $display("FAIL stats_count: got %0d/%0d, required 3/2", stat0_cnt, stat1_cnt);
            errors++;
        end
        force dut.stat0_q = 16'hFFFF;
        tick();
        release dut.stat0_q;
        do_op(0, 32'd1, 32'd1, 1'b0, 3'd4, d, c);
        tick();
        checks++;
        if (stat0_cnt !== 16'hFFFF) begin
            $display("FAIL stats_saturate: got %h, required ffff", stat0_cnt);
            errors++;
        end
`else
        checks++;
        if (stat0_cnt !== 16'h0 || stat1_cnt !== 16'h0) begin
            $display("FAIL stats_disabled: got %h/%h, required 0/0", stat0_cnt, stat1_cnt);
            errors++;
        end
`endif
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_ci = 1'b0; req0_op = '0;
        req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_ci = 1'b0; req1_op = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_shift();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
